// File: rtl/cflog_pkg.sv
// Shared types and constants for the control-flow log write path.
package cflog_pkg;

  localparam int unsigned CFLOG_PTR_W = 16;
  localparam logic [CFLOG_PTR_W-1:0] CFLOG_LOG_WORDS_DEF = 16'h0080;

  typedef enum logic {
    StRun  = 1'b0,
    StFull = 1'b1
  } cflog_state_e;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
  } cflog_entry_t;

  // Rewind targets are forced to an entry boundary and never point past the log end.
  function automatic logic [CFLOG_PTR_W-1:0] cflog_rewind_target(
    input logic [CFLOG_PTR_W-1:0] req,
    input logic [CFLOG_PTR_W-1:0] limit
  );
    logic [CFLOG_PTR_W-1:0] even;
    even = req & 16'hFFFE;
    return (even > limit) ? limit : even;
  endfunction

endpackage

// File: rtl/cflog_evt_fifo.sv
// Synchronous FIFO of (src, dest) branch events; push is ignored when full, pop when empty.
module cflog_evt_fifo
  import cflog_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  cflog_entry_t       din_i,
  input  logic               pop_i,
  output cflog_entry_t       head_o,
  output logic [FIFO_AW:0]   level_o,
  output logic               empty_o,
  output logic               full_o
);

  cflog_entry_t       mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               do_push, do_pop;

  assign full_o  = (level_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cflog_wr_ctrl.sv
// Control-flow log write controller: buffers branch events and drives the log HW write port.
// Define CFLOG_WRAP_EN to wrap to the log start instead of stalling when the log is full.
module cflog_wr_ctrl
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_WORDS  = CFLOG_LOG_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  input  logic             ev_valid,
  input  logic [15:0]      ev_src,
  input  logic [15:0]      ev_dest,
  output logic             ev_ready,
  input  logic             spec_busy,
  input  logic             spec_rewind_valid,
  input  logic [15:0]      spec_rewind_ptr,
  input  logic             flush_ack,
  output logic [15:0]      cflow_logs_ptr_din,
  output logic [15:0]      cflow_src,
  output logic [15:0]      cflow_dest,
  output logic             cflow_hw_wen,
  output logic             log_full,
  output logic [FIFO_AW:0] fifo_level
);

  cflog_state_e state_q, state_d;
  logic [15:0]  ptr_q, ptr_d, src_q, src_d, dest_q, dest_d;
  logic         wen_q, wen_d;
  logic         fifo_empty, fifo_full, push, pop, wrap;
  cflog_entry_t head, din;
  logic [16:0]  ptr_plus2;
  logic [15:0]  rewind_ptr;
  logic         fits, rewind_fits;

  // Compares are 17 bits wide so ptr+2 cannot wrap past zero.
  assign ptr_plus2   = {1'b0, ptr_q} + 17'd2;
  assign fits        = (ptr_plus2 <= {1'b0, LOG_WORDS});
  assign rewind_ptr  = cflog_rewind_target(spec_rewind_ptr, LOG_WORDS);
  assign rewind_fits = (({1'b0, rewind_ptr} + 17'd2) <= {1'b0, LOG_WORDS});

  assign ev_ready = ~fifo_full;
  assign push     = ev_valid & ev_ready;
  assign din      = '{src: ev_src, dest: ev_dest};

  cflog_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk_i   (mclk),
    .rst_ni  (puc_rst_n),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (fifo_level),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) state_q <= StRun;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
`ifndef CFLOG_WRAP_EN
        if (!spec_rewind_valid && !flush_ack && !fifo_empty && !fits) state_d = StFull;
`endif
      end
      StFull: begin
        if (spec_rewind_valid) begin
          if (rewind_fits) state_d = StRun;
        end else if (flush_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    wrap = 1'b0;
    if (state_q == StRun && !fifo_empty && !spec_busy && !spec_rewind_valid) begin
`ifdef CFLOG_WRAP_EN
      pop  = 1'b1;
      wrap = ~fits;
`else
      pop  = fits;
`endif
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    src_d  = src_q;
    dest_d = dest_q;
    wen_d  = 1'b0;
    if (spec_rewind_valid) begin
      ptr_d = rewind_ptr;
    end else if (flush_ack) begin
      // A pop coinciding with a flush lands at words 0-1 of the fresh log.
      ptr_d = pop ? 16'd2 : 16'd0;
    end else if (pop) begin
      ptr_d = wrap ? 16'd2 : ptr_plus2[15:0];
    end
    if (pop) begin
      src_d  = head.src;
      dest_d = head.dest;
      wen_d  = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ptr_q  <= '0;
      src_q  <= '0;
      dest_q <= '0;
      wen_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      src_q  <= src_d;
      dest_q <= dest_d;
      wen_q  <= wen_d;
    end
  end

`ifdef CFLOG_WRAP_EN
  logic wrapped_q;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)           wrapped_q <= 1'b0;
    else if (flush_ack)       wrapped_q <= 1'b0;
    else if (pop && wrap)     wrapped_q <= 1'b1;
  end

  assign log_full = wrapped_q;
`else
  assign log_full = (state_q == StFull);
`endif

  assign cflow_logs_ptr_din = ptr_q;
  assign cflow_src          = src_q;
  assign cflow_dest         = dest_q;
  assign cflow_hw_wen       = wen_q;

endmodule
